decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Registered RISC-V decode stage: decodes InstrD (control and immediate) and captures the ID/EX pipeline register.
- Detects load-use hazards internally against the instruction it holds and inserts bubbles.
- Datapath widths are parametrised by XLEN. Sits between the IF/ID register and the execute stage; register file read data arrives as inputs.

Parameters:
- XLEN, 32, datapath width; immediates sign-extended to XLEN.
- ALUCTRL_W, 3, width of ALU control field (min 3).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- InstrD  input  32  instruction in decode.
- PCD  input  XLEN  PC of InstrD.
- PCPlus4D  input  XLEN  PC+4 of InstrD.
- RD1D  input  XLEN  register file read data for rs1.
- RD2D  input  XLEN  register file read data for rs2.
- FlushE  input  1  branch/jump taken; squash E register.
- StallE  input  1  downstream hold of E register.
- StallFD  output  1  combinational; hold PC and IF/ID register.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered controls.
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  output  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  XLEN each  registered data.
- Rs1E, Rs2E, RdE  output  5 each  register addresses, for forwarding.
- ValidE  output  1  E register holds a real instruction.

Behaviour:
- Supported opcodes:
  - 0000011 lw: I-imm, ALUSrc=1, ResultSrc=01, RegWrite=1.
  - 0100011 sw: S-imm, MemWrite=1.
  - 0110011 R-type.
  - 0010011 I-type ALU.
  - 1100011 beq: B-imm, ALU sub, Branch=1.
  - 1101111 jal: J-imm, Jump=1, ResultSrc=10.
- ALU decode: funct3 000 is add, or sub when op[5]&funct7[5]; 010 slt; 110 or; 111 and.
- Unknown opcode: all controls 0, ValidE still follows the normal rules.
- Immediate sign bit is InstrD[31], replicated up to XLEN. B/J immediates have bit0 = 0.
- Rs1D=InstrD[19:15], Rs2D=InstrD[24:20], RdD=InstrD[11:7].
- Rs1 is used by all opcodes except jal. Rs2 is used by R-type, sw and beq.
- LoadUse = ValidE & ResultSrcE==01 & RdE!=0 & ((RdE==Rs1D & usesRs1) | (RdE==Rs2D & usesRs2)).
- StallFD = StallE | (LoadUse & ~FlushE).
- E register update, per rising edge, priority order:
  1. FlushE: bubble.
  2. StallE: hold all E outputs.
  3. LoadUse: bubble.
  4. Otherwise: load decoded values, ValidE=1.
- Bubble: ValidE=0; all control, data and address outputs = 0.
- Latency: one cycle from D inputs to E outputs.
- Reset (async, rst_n=0): all E outputs 0 immediately, ValidE=0; StallFD=0 while reset is held.
- Reset deasserting mid-stream: the first clock edge loads InstrD normally.
- FlushE and LoadUse together: bubble, and StallFD=0 (the stalled instruction is squashed upstream).
- StallE and LoadUse together: hold, StallFD=1. The hazard persists until StallE drops, then a bubble is inserted.
- rd=x0 never triggers LoadUse.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- With the macro:
  - Extra output IllegalE (1 bit) is registered.
  - IllegalE=1 for an unknown opcode or an unsupported funct3 on R/I-ALU.
  - The instruction loads with ValidE=1 and all write/branch controls forced 0.
  - IllegalE is cleared by bubble and reset, and held by StallE.
- Without the macro: no IllegalE port; unknown encodings decode as all-zero controls.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams.
  - ResultSrc, ImmSrc (00 I, 01 S, 10 B, 11 J) and ALUControl encodings.
  - typedef ctrl_t: packed struct of all control bits.
- Sub-module decode_ctrl: combinational opcode/funct to ctrl_t plus usesRs1/usesRs2.
- Immediate extension and the E register live in the top.

Test Plan:
- Reset: rst_n=0 mid-cycle with ValidE=1 -> all E outputs 0 asynchronously, StallFD=0.
- Decode: InstrD=0x00500093 (addi x1,x0,5) -> next edge ImmExtE=5, ALUSrcE=1, RegWriteE=1, RdE=1, ValidE=1.
- Immediates:
  - InstrD=0xFE000CE3 (beq x0,x0,-8) -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001.
  - InstrD=0x010000EF (jal x1,16) -> ImmExtE=16, ResultSrcE=10.
- Load-use: 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) -> StallFD=1 for one cycle, bubble in E, add lands one cycle later with Rs1E=2.
- Priority:
  - FlushE=1 together with LoadUse -> bubble, StallFD=0.
  - StallE=1 for 3 cycles -> E outputs unchanged, StallFD=1.
- Illegal: InstrD=0xFFFFFFFF -> with DECODE_ILLEGAL_TRAP_EN, IllegalE=1, ValidE=1, RegWriteE=0; without it, all controls 0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcode, control-field encodings and the decoded control bundle
// shared by the decode stage and its control decoder.
package decode_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic       regWrite;
      logic       memWrite;
      logic       jump;
      logic       branch;
      logic       aluSrc;
      logic [1:0] resultSrc;
      logic [1:0] immSrc;
      logic [2:0] aluControl;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   function automatic logic [2:0] aluDecode(input logic [2:0] funct3, input logic subEn);
      logic [2:0] code;
      case (funct3)
         3'b000:  code = subEn ? ALU_SUB : ALU_ADD;
         3'b010:  code = ALU_SLT;
         3'b110:  code = ALU_OR;
         3'b111:  code = ALU_AND;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   function automatic logic funct3Supported(input logic [2:0] funct3);
      logic ok;
      case (funct3)
         3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational opcode/funct decode into ctrl_t plus register-use flags.
// With DECODE_ILLEGAL_TRAP_EN it also flags unsupported encodings.
module decode_ctrl
   import decode_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output ctrl_t      ctrl,
   output logic       usesRs1,
   output logic       usesRs2
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,
   output logic       illegal
`endif
);

   // Main control decode; unknown opcodes fall through to all-zero controls.
   always_comb begin
      ctrl    = CTRL_NONE;
      usesRs1 = 1'b1;
      usesRs2 = 1'b0;
      case (op)
         OP_LOAD: begin
            ctrl.regWrite  = 1'b1;
            ctrl.aluSrc    = 1'b1;
            ctrl.resultSrc = RES_MEM;
            ctrl.immSrc    = IMM_I;
         end
         OP_STORE: begin
            ctrl.memWrite = 1'b1;
            ctrl.aluSrc   = 1'b1;
            ctrl.immSrc   = IMM_S;
            usesRs2       = 1'b1;
         end
         OP_RTYPE: begin
            ctrl.regWrite   = 1'b1;
            ctrl.aluControl = aluDecode(funct3, op[5] & funct7b5);
            usesRs2         = 1'b1;
         end
         OP_ITYPE: begin
            ctrl.regWrite   = 1'b1;
            ctrl.aluSrc     = 1'b1;
            ctrl.immSrc     = IMM_I;
            ctrl.aluControl = aluDecode(funct3, op[5] & funct7b5);
         end
         OP_BRANCH: begin
            ctrl.branch     = 1'b1;
            ctrl.immSrc     = IMM_B;
            ctrl.aluControl = ALU_SUB;
            usesRs2         = 1'b1;
         end
         OP_JAL: begin
            ctrl.regWrite  = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.resultSrc = RES_PC4;
            ctrl.immSrc    = IMM_J;
            usesRs1        = 1'b0;
         end
         default: begin
            ctrl = CTRL_NONE;
         end
      endcase
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   // Illegal-encoding detection: unknown opcode or an ALU funct3 we do not implement.
   always_comb begin
      case (op)
         OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: illegal = 1'b0;
         OP_RTYPE, OP_ITYPE:                   illegal = ~funct3Supported(funct3);
         default:                              illegal = 1'b1;
      endcase
   end
`endif

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RISC-V decode, immediate extension and ID/EX register with
// load-use bubble insertion. DECODE_ILLEGAL_TRAP_EN adds a registered IllegalE flag.
module decode_stage_pipe
   import decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ALUCTRL_W = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          InstrD,
   input  logic [XLEN-1:0]      PCD,
   input  logic [XLEN-1:0]      PCPlus4D,
   input  logic [XLEN-1:0]      RD1D,
   input  logic [XLEN-1:0]      RD2D,
   input  logic                 FlushE,
   input  logic                 StallE,
   output logic                 StallFD,
   output logic                 RegWriteE,
   output logic                 MemWriteE,
   output logic                 JumpE,
   output logic                 BranchE,
   output logic                 ALUSrcE,
   output logic [1:0]           ResultSrcE,
   output logic [ALUCTRL_W-1:0] ALUControlE,
   output logic [XLEN-1:0]      RD1E,
   output logic [XLEN-1:0]      RD2E,
   output logic [XLEN-1:0]      ImmExtE,
   output logic [XLEN-1:0]      PCE,
   output logic [XLEN-1:0]      PCPlus4E,
   output logic [4:0]           Rs1E,
   output logic [4:0]           Rs2E,
   output logic [4:0]           RdE,
   output logic                 ValidE
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,
   output logic                 IllegalE
`endif
);

   typedef struct packed {
      logic            valid;
      logic            regWrite;
      logic            memWrite;
      logic            jump;
      logic            branch;
      logic            aluSrc;
      logic [1:0]      resultSrc;
      logic [2:0]      aluControl;
`ifdef DECODE_ILLEGAL_TRAP_EN
      logic            illegal;
`endif
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcPlus4;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
   } eStage_t;

   ctrl_t           ctrlD_s;
   logic            usesRs1_s;
   logic            usesRs2_s;
   logic            writeKill_s;
   logic [4:0]      rs1D_s;
   logic [4:0]      rs2D_s;
   logic [4:0]      rdD_s;
   logic [XLEN-1:0] immExtD_s;
   logic            loadUse_s;
   eStage_t         eNext_s;
   eStage_t         eStage_r;

   assign rs1D_s = InstrD[19:15];
   assign rs2D_s = InstrD[24:20];
   assign rdD_s  = InstrD[11:7];

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic illegalD_s;

   decode_ctrl uCtrl (
      .op       (InstrD[6:0]),
      .funct3   (InstrD[14:12]),
      .funct7b5 (InstrD[30]),
      .ctrl     (ctrlD_s),
      .usesRs1  (usesRs1_s),
      .usesRs2  (usesRs2_s),
      .illegal  (illegalD_s)
   );

   // Illegal encodings still occupy E but must not write state or redirect flow.
   assign writeKill_s = illegalD_s;
`else
   decode_ctrl uCtrl (
      .op       (InstrD[6:0]),
      .funct3   (InstrD[14:12]),
      .funct7b5 (InstrD[30]),
      .ctrl     (ctrlD_s),
      .usesRs1  (usesRs1_s),
      .usesRs2  (usesRs2_s)
   );

   assign writeKill_s = 1'b0;
`endif

   // Immediate extension; every format takes its sign from InstrD[31].
   always_comb begin
      case (ctrlD_s.immSrc)
         IMM_I:   immExtD_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
         IMM_S:   immExtD_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   immExtD_s = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_J:   immExtD_s = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         default: immExtD_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      endcase
   end

   // Assemble the value E takes when the decoded instruction advances.
   always_comb begin
      eNext_s            = '0;
      eNext_s.valid      = 1'b1;
      eNext_s.regWrite   = ctrlD_s.regWrite & ~writeKill_s;
      eNext_s.memWrite   = ctrlD_s.memWrite & ~writeKill_s;
      eNext_s.jump       = ctrlD_s.jump & ~writeKill_s;
      eNext_s.branch     = ctrlD_s.branch & ~writeKill_s;
      eNext_s.aluSrc     = ctrlD_s.aluSrc;
      eNext_s.resultSrc  = ctrlD_s.resultSrc;
      eNext_s.aluControl = ctrlD_s.aluControl;
`ifdef DECODE_ILLEGAL_TRAP_EN
      eNext_s.illegal    = illegalD_s;
`endif
      eNext_s.rd1        = RD1D;
      eNext_s.rd2        = RD2D;
      eNext_s.imm        = immExtD_s;
      eNext_s.pc         = PCD;
      eNext_s.pcPlus4    = PCPlus4D;
      eNext_s.rs1        = rs1D_s;
      eNext_s.rs2        = rs2D_s;
      eNext_s.rd         = rdD_s;
   end

   // A load in E whose destination the decoding instruction reads must wait a cycle.
   assign loadUse_s = eStage_r.valid
                    & (eStage_r.resultSrc == RES_MEM)
                    & (eStage_r.rd != 5'd0)
                    & (((eStage_r.rd == rs1D_s) & usesRs1_s)
                     | ((eStage_r.rd == rs2D_s) & usesRs2_s));

   // Gated by rst_n so upstream never sees a stall while the pipe is being reset.
   assign StallFD = rst_n & (StallE | (loadUse_s & ~FlushE));

   // ID/EX register: flush beats downstream hold, which beats the load-use bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eStage_r <= '0;
      end else if (FlushE) begin
         eStage_r <= '0;
      end else if (StallE) begin
         eStage_r <= eStage_r;
      end else if (loadUse_s) begin
         eStage_r <= '0;
      end else begin
         eStage_r <= eNext_s;
      end
   end

   assign ValidE      = eStage_r.valid;
   assign RegWriteE   = eStage_r.regWrite;
   assign MemWriteE   = eStage_r.memWrite;
   assign JumpE       = eStage_r.jump;
   assign BranchE     = eStage_r.branch;
   assign ALUSrcE     = eStage_r.aluSrc;
   assign ResultSrcE  = eStage_r.resultSrc;
   assign ALUControlE = ALUCTRL_W'(eStage_r.aluControl);
   assign RD1E        = eStage_r.rd1;
   assign RD2E        = eStage_r.rd2;
   assign ImmExtE     = eStage_r.imm;
   assign PCE         = eStage_r.pc;
   assign PCPlus4E    = eStage_r.pcPlus4;
   assign Rs1E        = eStage_r.rs1;
   assign Rs2E        = eStage_r.rs2;
   assign RdE         = eStage_r.rd;
`ifdef DECODE_ILLEGAL_TRAP_EN
   assign IllegalE    = eStage_r.illegal;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: table vectors, hand-written hazard/priority/reset sequences
// and randomized traffic against a rule-level reference model of the decode stage.
module tb_decode_stage_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
   logic        FlushE, StallE, StallFD;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        IllegalE;
`endif

   decode_stage_pipe #(.XLEN(32), .ALUCTRL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RD1D(RD1D), .RD2D(RD2D), .FlushE(FlushE), .StallE(StallE), .StallFD(StallFD),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE)
`ifdef DECODE_ILLEGAL_TRAP_EN
      , .IllegalE(IllegalE)
`endif
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid, regWrite, memWrite, jump, branch, aluSrc;
      logic [1:0]  resultSrc;
      logic [2:0]  aluControl;
      logic        illegal;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
   } eOut_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic        immCare;
      logic [9:0]  ctl;
      logic [4:0]  rd;
      logic        ill;
   } vec_t;

   int     errCnt = 0;
   int     chkCnt = 0;
   eOut_t  model;
   logic   immCare;
   logic   lastStall;
   vec_t   vecs[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic eOut_t actualE();
      eOut_t a;
      a.valid = ValidE; a.regWrite = RegWriteE; a.memWrite = MemWriteE;
      a.jump = JumpE; a.branch = BranchE; a.aluSrc = ALUSrcE;
      a.resultSrc = ResultSrcE; a.aluControl = ALUControlE;
`ifdef DECODE_ILLEGAL_TRAP_EN
      a.illegal = IllegalE;
`else
      a.illegal = 1'b0;
`endif
      a.rd1 = RD1E; a.rd2 = RD2E; a.imm = ImmExtE; a.pc = PCE; a.pc4 = PCPlus4E;
      a.rs1 = Rs1E; a.rs2 = Rs2E; a.rd = RdE;
      return a;
   endfunction

   function automatic logic [2:0] aluRef(input logic [2:0] f3, input logic isSub);
      case (f3)
         3'd0:    return isSub ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Reference decode, immediates built arithmetically from the field weights.
   function automatic eOut_t decodeRef(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] rd1, input logic [31:0] rd2,
                                       output logic care);
      eOut_t e;
      int imm;
      logic bad;
      e = '0; e.valid = 1'b1;
      e.rd1 = rd1; e.rd2 = rd2; e.pc = pc; e.pc4 = pc + 32'd4;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      imm = $signed(ins) >>> 20;
      care = 1'b1;
      bad = 1'b0;
      case (ins[6:0])
         7'b0000011: begin e.regWrite = 1'b1; e.aluSrc = 1'b1; e.resultSrc = 2'b01; end
         7'b0100011: begin
            e.memWrite = 1'b1; e.aluSrc = 1'b1;
            imm = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
         end
         7'b0110011: begin
            e.regWrite = 1'b1; e.aluControl = aluRef(ins[14:12], ins[30]); care = 1'b0;
            bad = !(ins[14:12] inside {3'd0, 3'd2, 3'd6, 3'd7});
         end
         7'b0010011: begin
            e.regWrite = 1'b1; e.aluSrc = 1'b1; e.aluControl = aluRef(ins[14:12], 1'b0);
            bad = !(ins[14:12] inside {3'd0, 3'd2, 3'd6, 3'd7});
         end
         7'b1100011: begin
            e.branch = 1'b1; e.aluControl = 3'b001;
            imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                + int'(ins[11:8]) * 2;
         end
         7'b1101111: begin
            e.jump = 1'b1; e.regWrite = 1'b1; e.resultSrc = 2'b10;
            imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         end
         default: begin care = 1'b0; bad = 1'b1; end
      endcase
      e.imm = imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (bad) begin
         e.illegal = 1'b1; e.regWrite = 1'b0; e.memWrite = 1'b0; e.jump = 1'b0; e.branch = 1'b0;
      end
`endif
      return e;
   endfunction

   function automatic logic loadUseRef(input logic [31:0] ins);
      logic [6:0] op;
      logic r1, r2;
      op = ins[6:0];
      r1 = (op != 7'b1101111);
      r2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
      return model.valid && (model.resultSrc == 2'b01) && (model.rd != 5'd0)
          && (((model.rd == ins[19:15]) && r1) || ((model.rd == ins[24:20]) && r2));
   endfunction

   function automatic logic [31:0] genInstr();
      logic [31:0] ins;
      logic [6:0]  op;
      int k;
      ins = $urandom;
      k = $urandom_range(0, 6);
      case (k)
         0: op = 7'b0000011;
         1: op = 7'b0100011;
         2: op = 7'b0110011;
         3: op = 7'b0010011;
         4: op = 7'b1100011;
         5: op = 7'b1101111;
         default: begin
            op = 7'($urandom);
            while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b1100011, 7'b1101111})
               op = 7'($urandom);
         end
      endcase
      ins[6:0]   = op;
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      case (k)
         0, 1: ins[14:12] = 3'd2;
         2, 3: begin
            case ($urandom_range(0, 3))
               0: ins[14:12] = 3'd0;
               1: ins[14:12] = 3'd2;
               2: ins[14:12] = 3'd6;
               default: ins[14:12] = 3'd7;
            endcase
         end
         4: ins[14:12] = 3'd0;
         default: ;
      endcase
      return ins;
   endfunction

   // One pipeline cycle: drive at negedge, check StallFD, then check E after posedge.
   task automatic doCycle(input logic [31:0] ins, input logic flush, input logic stall);
      logic [31:0] pc;
      eOut_t nxt;
      logic nxtCare;
      logic lu;
      eOut_t act;
      @(negedge clk);
      pc = $urandom & 32'hFFFF_FFFC;
      InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
      RD1D = $urandom; RD2D = $urandom; FlushE = flush; StallE = stall;
      #1;
      lu = loadUseRef(ins);
      lastStall = StallFD;
      chk("StallFD", StallFD, stall | (lu & ~flush));
      if (flush) begin
         nxt = '0; nxtCare = 1'b1;
      end else if (stall) begin
         nxt = model; nxtCare = immCare;
      end else if (lu) begin
         nxt = '0; nxtCare = 1'b1;
      end else begin
         nxt = decodeRef(ins, pc, RD1D, RD2D, nxtCare);
      end
      @(posedge clk);
      #1;
      model = nxt; immCare = nxtCare;
      act = actualE();
      if (!immCare) act.imm = model.imm;
      chk("E-stage", act, model);
   endtask

   initial begin
      logic [31:0] cur;
      rst_n = 1'b0; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h0;
      RD1D = 32'h0; RD2D = 32'h0; FlushE = 1'b0; StallE = 1'b1;
      model = '0; immCare = 1'b1; lastStall = 1'b0;

      #12;
      chk("reset E", actualE(), 256'd0);
      chk("reset StallFD", StallFD, 1'b0);
      StallE = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // {instr, imm, immCare, {RegW,MemW,Jump,Branch,ALUSrc,ResultSrc,ALUCtl}, rd, illegal}
      vecs.push_back('{32'h00500093, 32'h00000005, 1'b1, 10'b10001_00_000, 5'd1,  1'b0});
      vecs.push_back('{32'hFE000CE3, 32'hFFFFFFF8, 1'b1, 10'b00010_00_001, 5'd25, 1'b0});
      vecs.push_back('{32'h010000EF, 32'h00000010, 1'b1, 10'b10100_10_000, 5'd1,  1'b0});
      vecs.push_back('{32'h0000A103, 32'h00000000, 1'b1, 10'b10001_01_000, 5'd2,  1'b0});
      vecs.push_back('{32'hFE50AE23, 32'hFFFFFFFC, 1'b1, 10'b01001_00_000, 5'd28, 1'b0});
      vecs.push_back('{32'h404081B3, 32'h00000000, 1'b0, 10'b10000_00_001, 5'd3,  1'b0});
      vecs.push_back('{32'h007372B3, 32'h00000000, 1'b0, 10'b10000_00_010, 5'd5,  1'b0});
      vecs.push_back('{32'hFFF0A213, 32'hFFFFFFFF, 1'b1, 10'b10001_00_101, 5'd4,  1'b0});
      vecs.push_back('{32'h7FF06313, 32'h000007FF, 1'b1, 10'b10001_00_011, 5'd6,  1'b0});
      vecs.push_back('{32'hC0000093, 32'hFFFFFC00, 1'b1, 10'b10001_00_000, 5'd1,  1'b0});
      vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b0, 10'b00000_00_000, 5'd31, 1'b1});
`ifdef DECODE_ILLEGAL_TRAP_EN
      vecs.push_back('{32'h00001093, 32'h00000000, 1'b1, 10'b00001_00_000, 5'd1,  1'b1});
`endif
      foreach (vecs[i]) begin
         doCycle(vecs[i].instr, 1'b0, 1'b0);
         chk($sformatf("tbl%0d valid", i), ValidE, 1'b1);
         chk($sformatf("tbl%0d ctl", i),
             {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}, vecs[i].ctl);
         chk($sformatf("tbl%0d rd", i), RdE, vecs[i].rd);
         if (vecs[i].immCare) chk($sformatf("tbl%0d imm", i), ImmExtE, vecs[i].imm);
`ifdef DECODE_ILLEGAL_TRAP_EN
         chk($sformatf("tbl%0d illegal", i), IllegalE, vecs[i].ill);
`endif
      end

      // lw x2 then dependent add: one stall cycle, a bubble, then the add.
      doCycle(32'h0000A103, 1'b0, 1'b0);
      doCycle(32'h001101B3, 1'b0, 1'b0);
      chk("lu stall", lastStall, 1'b1);
      chk("lu bubble", ValidE, 1'b0);
      doCycle(32'h001101B3, 1'b0, 1'b0);
      chk("lu release", lastStall, 1'b0);
      chk("lu add valid", ValidE, 1'b1);
      chk("lu add rs1", Rs1E, 5'd2);

      // Flush coincident with a load-use hazard.
      doCycle(32'h0000A103, 1'b0, 1'b0);
      doCycle(32'h001101B3, 1'b1, 1'b0);
      chk("flush+lu stall", lastStall, 1'b0);
      chk("flush+lu bubble", ValidE, 1'b0);

      // Downstream hold for three cycles.
      doCycle(32'h00500093, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         doCycle(genInstr(), 1'b0, 1'b1);
         chk("hold stall", lastStall, 1'b1);
         chk("hold imm", ImmExtE, 32'd5);
         chk("hold rd/valid", {RdE, ValidE}, {5'd1, 1'b1});
      end

      // Hold overlapping a load-use hazard, then the bubble once the hold drops.
      doCycle(32'h0000A103, 1'b0, 1'b0);
      doCycle(32'h001101B3, 1'b0, 1'b1);
      chk("hold+lu stall", lastStall, 1'b1);
      chk("hold+lu kept lw", {ValidE, ResultSrcE}, {1'b1, 2'b01});
      doCycle(32'h001101B3, 1'b0, 1'b0);
      chk("hold+lu late stall", lastStall, 1'b1);
      chk("hold+lu bubble", ValidE, 1'b0);
      doCycle(32'h001101B3, 1'b0, 1'b0);
      chk("hold+lu add", {ValidE, RdE}, {1'b1, 5'd3});

      // Load into x0 never creates a hazard.
      doCycle(32'h0000A003, 1'b0, 1'b0);
      doCycle(32'h001001B3, 1'b0, 1'b0);
      chk("x0 no stall", lastStall, 1'b0);
      chk("x0 add valid", ValidE, 1'b1);

      // Asynchronous reset in mid-cycle, then the first edge loads normally.
      doCycle(32'h00500093, 1'b0, 1'b0);
      #2;
      StallE = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("async reset E", actualE(), 256'd0);
      chk("async reset StallFD", StallFD, 1'b0);
      model = '0; immCare = 1'b1;
      StallE = 1'b0;
      rst_n = 1'b1;
      doCycle(32'h00500093, 1'b0, 1'b0);
      chk("post-reset load", {ValidE, ImmExtE}, {1'b1, 32'd5});

      // Randomized traffic; upstream holds its instruction whenever StallFD was high.
      cur = 32'h00000013;
      for (int i = 0; i < 500; i++) begin
         if (!lastStall) cur = genInstr();
         doCycle(cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
